ms_pulse_sched: RTL

Run controller for the millisecond pulse generator. It issues the generator's `start`/`stop` controls, counts the generator's `msclock` output, and ends a run after a programmed number of milliseconds. Pause, resume and abort are supported. It sits between the board's control inputs and the pulse generator instance in the top level, and replaces direct button wiring of `start`/`stop`.

---
 rtl/ms_pulse_sched_if.sv | 27 ++
 rtl/ms_pulse_sched.sv | 110 +++++++++++
 2 files changed

// File: rtl/ms_pulse_sched_if.sv
// Control/status bundle between the run controller and its user.
// The master side drives run controls and the generator's msclock; the slave side is the controller.
interface ms_pulse_sched_if #(
   parameter int CNT_W = 16
);
   logic             go;
   logic             pause;
   logic             halt;
   logic [CNT_W-1:0] duration;
   logic             ms_in;
   logic             pg_start;
   logic             pg_stop;
   logic             busy;
   logic             done;
   logic             aborted;
   logic [CNT_W-1:0] elapsed;

   modport master (
      output go, pause, halt, duration, ms_in,
      input  pg_start, pg_stop, busy, done, aborted, elapsed
   );

   modport slave (
      input  go, pause, halt, duration, ms_in,
      output pg_start, pg_stop, busy, done, aborted, elapsed
   );
endinterface

// File: rtl/ms_pulse_sched.sv
// Run controller for the millisecond pulse generator: issues start/stop pulses,
// counts msclock rising edges and ends the run after a programmed number of ms.
module ms_pulse_sched #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   ms_pulse_sched_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_PAUSED = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_ms_prev;
   logic [CNT_W-1:0] r_target;
   logic [CNT_W-1:0] r_elapsed;
   logic             r_pg_start;
   logic             r_pg_stop;
   logic             r_done;
   logic             r_aborted;

   logic             w_tick;
   logic [CNT_W-1:0] w_elapsed_inc;

   assign w_tick        = bus.ms_in & ~r_ms_prev;
   assign w_elapsed_inc = r_elapsed + {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ms_prev  <= 1'b0;
         r_target   <= '0;
         r_elapsed  <= '0;
         r_pg_start <= 1'b0;
         r_pg_stop  <= 1'b0;
         r_done     <= 1'b0;
         r_aborted  <= 1'b0;
      end else begin
         // Edge history always advances so a level held across states never reads as a fresh tick.
         r_ms_prev  <= bus.ms_in;
         r_pg_start <= 1'b0;
         r_pg_stop  <= 1'b0;
         r_done     <= 1'b0;
         r_aborted  <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (bus.go) begin
                  r_elapsed <= '0;
                  if (bus.duration != '0) begin
                     r_target   <= bus.duration;
                     r_pg_start <= 1'b1;
                     r_state    <= S_RUN;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end

            S_RUN: begin
               if (bus.halt) begin
                  r_pg_stop <= 1'b1;
                  r_aborted <= 1'b1;
                  r_state   <= S_IDLE;
               end else if (w_tick && (w_elapsed_inc == r_target)) begin
                  r_elapsed <= r_target;
                  r_pg_stop <= 1'b1;
                  r_done    <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  // A tick coincident with pause is still counted before suspending.
                  if (w_tick) begin
                     r_elapsed <= w_elapsed_inc;
                  end
                  if (bus.pause) begin
                     r_pg_stop <= 1'b1;
                     r_state   <= S_PAUSED;
                  end
               end
            end

            S_PAUSED: begin
               if (bus.halt) begin
                  r_aborted <= 1'b1;
                  r_state   <= S_IDLE;
               end else if (bus.go) begin
                  r_pg_start <= 1'b1;
                  r_state    <= S_RUN;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = (r_state == S_RUN) || (r_state == S_PAUSED);
   assign bus.pg_start = r_pg_start;
   assign bus.pg_stop  = r_pg_stop;
   assign bus.done     = r_done;
   assign bus.aborted  = r_aborted;
   assign bus.elapsed  = r_elapsed;

endmodule
